// File: rtl/sal_cmd_arbiter_if.sv
// sal_cmd_arbiter_if
// Request, grant and issued-command bundle between the per-bank controllers,
// the command arbiter and the downstream command/data scheduler.
//   act_req/rd_req/wr_req/pre_req : per-bank command requests
//   req_ra/req_ca/req_id/req_len  : per-bank packed command fields
//   act_gnt/rd_gnt/wr_gnt/pre_gnt : one-hot grants, combinational
//   cmd_*                         : registered issued command toward the PHY
// Modports: master = bank-controller/scheduler side, slave = arbiter side.
interface sal_cmd_arbiter_if #(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned BA_WIDTH  = 2,
   parameter int unsigned RA_WIDTH  = 16,
   parameter int unsigned CA_WIDTH  = 10,
   parameter int unsigned ID_WIDTH  = 4,
   parameter int unsigned LEN_WIDTH = 4
);
   logic [NUM_BANKS-1:0]           act_req;
   logic [NUM_BANKS-1:0]           rd_req;
   logic [NUM_BANKS-1:0]           wr_req;
   logic [NUM_BANKS-1:0]           pre_req;
   logic [NUM_BANKS*RA_WIDTH-1:0]  req_ra;
   logic [NUM_BANKS*CA_WIDTH-1:0]  req_ca;
   logic [NUM_BANKS*ID_WIDTH-1:0]  req_id;
   logic [NUM_BANKS*LEN_WIDTH-1:0] req_len;

   logic [NUM_BANKS-1:0]           act_gnt;
   logic [NUM_BANKS-1:0]           rd_gnt;
   logic [NUM_BANKS-1:0]           wr_gnt;
   logic [NUM_BANKS-1:0]           pre_gnt;

   logic                           cmd_valid;
   logic [1:0]                     cmd_type;
   logic [BA_WIDTH-1:0]            cmd_ba;
   logic [RA_WIDTH-1:0]            cmd_ra;
   logic [CA_WIDTH-1:0]            cmd_ca;
   logic [ID_WIDTH-1:0]            cmd_id;
   logic [LEN_WIDTH-1:0]           cmd_len;

   modport master (
      output act_req, rd_req, wr_req, pre_req, req_ra, req_ca, req_id, req_len,
      input  act_gnt, rd_gnt, wr_gnt, pre_gnt,
      input  cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
   );

   modport slave (
      input  act_req, rd_req, wr_req, pre_req, req_ra, req_ca, req_id, req_len,
      output act_gnt, rd_gnt, wr_gnt, pre_gnt,
      output cmd_valid, cmd_type, cmd_ba, cmd_ra, cmd_ca, cmd_id, cmd_len
   );
endinterface

// File: rtl/sal_cmd_arbiter.sv
// sal_cmd_arbiter
// Shares the DRAM command bus among NUM_BANKS bank controllers. Each cycle at
// most one ACT/RD/WR/PRE request is granted (class priority RD/WR > ACT > PRE,
// round-robin within a class) and the winner is registered onto cmd_* one
// cycle later. Enforces inter-bank tRRD, tFAW, tCCD, tWTR and tRTW.
//   clk, rst_n         : clock, asynchronous active-low reset
//   t_*_m1             : timing minus one, sampled only when a counter loads
//   bus (slave)        : requests/fields in, grants and issued command out
module sal_cmd_arbiter #(
   parameter int unsigned NUM_BANKS = 4,
   parameter int unsigned BA_WIDTH  = 2,
   parameter int unsigned RA_WIDTH  = 16,
   parameter int unsigned CA_WIDTH  = 10,
   parameter int unsigned ID_WIDTH  = 4,
   parameter int unsigned LEN_WIDTH = 4,
   parameter int unsigned TW        = 4
) (
   input logic           clk,
   input logic           rst_n,
   input logic [TW-1:0]  t_rrd_m1,
   input logic [TW-1:0]  t_ccd_m1,
   input logic [TW-1:0]  t_wtr_m1,
   input logic [TW-1:0]  t_rtw_m1,
   input logic [5:0]     t_faw_m1,
   sal_cmd_arbiter_if.slave bus
);

   localparam int unsigned FawDepth = 4;

   typedef enum logic [1:0] {CmdAct = 2'd0, CmdRd = 2'd1, CmdWr = 2'd2, CmdPre = 2'd3} cmd_e;

   // Returns {found, index} of the first set bit at or after ptr, wrapping.
   function automatic logic [BA_WIDTH:0] rr_pick(input logic [NUM_BANKS-1:0] req,
                                                 input logic [BA_WIDTH-1:0]  ptr);
      logic                found;
      logic [BA_WIDTH-1:0] idx;
      logic [BA_WIDTH-1:0] win;
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_BANKS; k++) begin
         idx = ptr + BA_WIDTH'(k);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
      return {found, win};
   endfunction

   logic [TW-1:0]               rrd_q, rrd_d, ccd_q, ccd_d, wtr_q, wtr_d, rtw_q, rtw_d;
   logic [FawDepth-1:0][5:0]    faw_q, faw_d;
   logic [BA_WIDTH-1:0]         rw_ptr_q, rw_ptr_d, act_ptr_q, act_ptr_d, pre_ptr_q, pre_ptr_d;

   logic                        cmd_valid_q;
   logic [1:0]                  cmd_type_q;
   logic [BA_WIDTH-1:0]         cmd_ba_q;
   logic [RA_WIDTH-1:0]         cmd_ra_q;
   logic [CA_WIDTH-1:0]         cmd_ca_q;
   logic [ID_WIDTH-1:0]         cmd_id_q;
   logic [LEN_WIDTH-1:0]        cmd_len_q;

   logic                        faw_free, act_ok, rd_ok, wr_ok;
   logic [NUM_BANKS-1:0]        rw_elig;
   logic [BA_WIDTH:0]           rw_pick, act_pick, pre_pick;
   logic                        issue;
   cmd_e                        sel_cmd;
   logic [BA_WIDTH-1:0]         sel_ba;
   logic [NUM_BANKS-1:0]        onehot;

   // A zero history entry means that slot's ACT has aged out of the window.
   always_comb begin
      faw_free = 1'b0;
      for (int i = 0; i < FawDepth; i++) begin
         if (faw_q[i] == 6'd0) faw_free = 1'b1;
      end
   end

   assign act_ok = (rrd_q == '0) && faw_free;
   assign rd_ok  = (ccd_q == '0) && (wtr_q == '0);
   assign wr_ok  = (ccd_q == '0) && (rtw_q == '0);

   // A bank is RD/WR-eligible if either of its requests is timing-clean, so a
   // blocked RD lets the search move on to a bank with a legal WR and vice versa.
   assign rw_elig  = (bus.rd_req & {NUM_BANKS{rd_ok}}) | (bus.wr_req & {NUM_BANKS{wr_ok}});
   assign rw_pick  = rr_pick(rw_elig, rw_ptr_q);
   assign act_pick = rr_pick(bus.act_req, act_ptr_q);
   assign pre_pick = rr_pick(bus.pre_req, pre_ptr_q);

   // Grants are gated by reset so nothing is granted while rst_n is low.
   always_comb begin
      issue   = 1'b0;
      sel_cmd = CmdAct;
      sel_ba  = '0;
      if (rst_n) begin
         if (rw_pick[BA_WIDTH]) begin
            issue   = 1'b1;
            sel_ba  = rw_pick[BA_WIDTH-1:0];
            sel_cmd = (rd_ok && bus.rd_req[sel_ba]) ? CmdRd : CmdWr;
         end else if (act_ok && act_pick[BA_WIDTH]) begin
            issue   = 1'b1;
            sel_ba  = act_pick[BA_WIDTH-1:0];
            sel_cmd = CmdAct;
         end else if (pre_pick[BA_WIDTH]) begin
            issue   = 1'b1;
            sel_ba  = pre_pick[BA_WIDTH-1:0];
            sel_cmd = CmdPre;
         end
      end
   end

   assign onehot      = NUM_BANKS'(1) << sel_ba;
   assign bus.act_gnt = (issue && sel_cmd == CmdAct) ? onehot : '0;
   assign bus.rd_gnt  = (issue && sel_cmd == CmdRd)  ? onehot : '0;
   assign bus.wr_gnt  = (issue && sel_cmd == CmdWr)  ? onehot : '0;
   assign bus.pre_gnt = (issue && sel_cmd == CmdPre) ? onehot : '0;

   // Counters saturate at zero; a load on issue overrides the decrement.
   always_comb begin
      logic loaded;
      loaded    = 1'b0;
      rrd_d     = (rrd_q != '0) ? rrd_q - TW'(1) : rrd_q;
      ccd_d     = (ccd_q != '0) ? ccd_q - TW'(1) : ccd_q;
      wtr_d     = (wtr_q != '0) ? wtr_q - TW'(1) : wtr_q;
      rtw_d     = (rtw_q != '0) ? rtw_q - TW'(1) : rtw_q;
      rw_ptr_d  = rw_ptr_q;
      act_ptr_d = act_ptr_q;
      pre_ptr_d = pre_ptr_q;
      for (int i = 0; i < FawDepth; i++) begin
         faw_d[i] = (faw_q[i] != 6'd0) ? faw_q[i] - 6'd1 : faw_q[i];
      end
      if (issue) begin
         unique case (sel_cmd)
            CmdAct: begin
               rrd_d     = t_rrd_m1;
               act_ptr_d = sel_ba + BA_WIDTH'(1);
               // Entries all load the same value, so any expired one is oldest.
               for (int i = 0; i < FawDepth; i++) begin
                  if (!loaded && faw_q[i] == 6'd0) begin
                     faw_d[i] = t_faw_m1;
                     loaded   = 1'b1;
                  end
               end
            end
            CmdRd: begin
               ccd_d    = t_ccd_m1;
               rtw_d    = t_rtw_m1;
               rw_ptr_d = sel_ba + BA_WIDTH'(1);
            end
            CmdWr: begin
               ccd_d    = t_ccd_m1;
               wtr_d    = t_wtr_m1;
               rw_ptr_d = sel_ba + BA_WIDTH'(1);
            end
            CmdPre: begin
               pre_ptr_d = sel_ba + BA_WIDTH'(1);
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rrd_q     <= '0;
         ccd_q     <= '0;
         wtr_q     <= '0;
         rtw_q     <= '0;
         faw_q     <= '0;
         rw_ptr_q  <= '0;
         act_ptr_q <= '0;
         pre_ptr_q <= '0;
      end else begin
         rrd_q     <= rrd_d;
         ccd_q     <= ccd_d;
         wtr_q     <= wtr_d;
         rtw_q     <= rtw_d;
         faw_q     <= faw_d;
         rw_ptr_q  <= rw_ptr_d;
         act_ptr_q <= act_ptr_d;
         pre_ptr_q <= pre_ptr_d;
      end
   end

   // Command fields hold their last value while cmd_valid is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_valid_q <= 1'b0;
         cmd_type_q  <= '0;
         cmd_ba_q    <= '0;
         cmd_ra_q    <= '0;
         cmd_ca_q    <= '0;
         cmd_id_q    <= '0;
         cmd_len_q   <= '0;
      end else begin
         cmd_valid_q <= issue;
         if (issue) begin
            cmd_type_q <= sel_cmd;
            cmd_ba_q   <= sel_ba;
            cmd_ra_q   <= bus.req_ra[sel_ba*RA_WIDTH +: RA_WIDTH];
            cmd_ca_q   <= bus.req_ca[sel_ba*CA_WIDTH +: CA_WIDTH];
            cmd_id_q   <= bus.req_id[sel_ba*ID_WIDTH +: ID_WIDTH];
            cmd_len_q  <= bus.req_len[sel_ba*LEN_WIDTH +: LEN_WIDTH];
         end
      end
   end

   assign bus.cmd_valid = cmd_valid_q;
   assign bus.cmd_type  = cmd_type_q;
   assign bus.cmd_ba    = cmd_ba_q;
   assign bus.cmd_ra    = cmd_ra_q;
   assign bus.cmd_ca    = cmd_ca_q;
   assign bus.cmd_id    = cmd_id_q;
   assign bus.cmd_len   = cmd_len_q;

endmodule

// File: tb/tb_sal_cmd_arbiter.sv
// tb_sal_cmd_arbiter
// Directed scenarios for sal_cmd_arbiter. Expected commands (fields and the
// cycle cmd_valid should appear) are queued when stimulus is set up; a monitor
// pops and compares each issued command. Banks drop a request after its grant.
module tb_sal_cmd_arbiter;

   localparam int unsigned NB   = 4;
   localparam int unsigned BAW  = 2;
   localparam int unsigned RAW  = 16;
   localparam int unsigned CAW  = 10;
   localparam int unsigned IDW  = 4;
   localparam int unsigned LENW = 4;
   localparam int unsigned TW   = 4;

   localparam logic [1:0] T_ACT = 2'd0;
   localparam logic [1:0] T_RD  = 2'd1;
   localparam logic [1:0] T_WR  = 2'd2;
   localparam logic [1:0] T_PRE = 2'd3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [TW-1:0] t_rrd_m1, t_ccd_m1, t_wtr_m1, t_rtw_m1;
   logic [5:0]    t_faw_m1;

   sal_cmd_arbiter_if #(
      .NUM_BANKS(NB), .BA_WIDTH(BAW), .RA_WIDTH(RAW),
      .CA_WIDTH(CAW), .ID_WIDTH(IDW), .LEN_WIDTH(LENW)
   ) bus ();

   sal_cmd_arbiter #(
      .NUM_BANKS(NB), .BA_WIDTH(BAW), .RA_WIDTH(RAW), .CA_WIDTH(CAW),
      .ID_WIDTH(IDW), .LEN_WIDTH(LENW), .TW(TW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .t_rrd_m1 (t_rrd_m1),
      .t_ccd_m1 (t_ccd_m1),
      .t_wtr_m1 (t_wtr_m1),
      .t_rtw_m1 (t_rtw_m1),
      .t_faw_m1 (t_faw_m1),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // Cycle index since the last reset release; a grant seen while cyc==N
   // yields cmd_valid while cyc==N+1.
   int cyc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   typedef struct {
      logic [1:0]      typ;
      logic [BAW-1:0]  ba;
      logic [RAW-1:0]  ra;
      logic [CAW-1:0]  ca;
      logic [IDW-1:0]  id;
      logic [LENW-1:0] len;
      int              vcyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   seed = 0;

   function automatic logic [RAW-1:0] f_ra(input int s, input int b);
      return RAW'(32'hA000 + s * 64 + b * 7);
   endfunction
   function automatic logic [CAW-1:0] f_ca(input int s, input int b);
      return CAW'(s * 37 + b * 5 + 3);
   endfunction
   function automatic logic [IDW-1:0] f_id(input int s, input int b);
      return IDW'(s + b * 3);
   endfunction
   function automatic logic [LENW-1:0] f_len(input int s, input int b);
      return LENW'(s * 2 + b + 1);
   endfunction

   task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_fields(input int s);
      seed = s;
      for (int b = 0; b < NB; b++) begin
         bus.req_ra[b*RAW +: RAW]    = f_ra(s, b);
         bus.req_ca[b*CAW +: CAW]    = f_ca(s, b);
         bus.req_id[b*IDW +: IDW]    = f_id(s, b);
         bus.req_len[b*LENW +: LENW] = f_len(s, b);
      end
   endtask

   task automatic expect_cmd(input logic [1:0] t, input int b, input int vcyc);
      exp_t e;
      e.typ  = t;
      e.ba   = BAW'(b);
      e.ra   = f_ra(seed, b);
      e.ca   = f_ca(seed, b);
      e.id   = f_id(seed, b);
      e.len  = f_len(seed, b);
      e.vcyc = vcyc;
      sb.push_back(e);
   endtask

   // Called at a falling edge: sample grants, cross the rising edge, then the
   // granted banks drop their requests.
   task automatic tick();
      logic [NB-1:0] ag, rg, wg, pg;
      #1;
      ag = bus.act_gnt;
      rg = bus.rd_gnt;
      wg = bus.wr_gnt;
      pg = bus.pre_gnt;
      @(negedge clk);
      bus.act_req = bus.act_req & ~ag;
      bus.rd_req  = bus.rd_req & ~rg;
      bus.wr_req  = bus.wr_req & ~wg;
      bus.pre_req = bus.pre_req & ~pg;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic clear_inputs();
      bus.act_req = '0;
      bus.rd_req  = '0;
      bus.wr_req  = '0;
      bus.pre_req = '0;
      t_rrd_m1 = '0;
      t_ccd_m1 = '0;
      t_wtr_m1 = '0;
      t_rtw_m1 = '0;
      t_faw_m1 = '0;
   endtask

   task automatic do_reset(input int s);
      @(negedge clk);
      rst_n = 1'b0;
      clear_inputs();
      set_fields(s);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst_n) begin
            check_eq("gnt_onehot",
                     32'($countones({bus.act_gnt, bus.rd_gnt, bus.wr_gnt, bus.pre_gnt}) <= 1),
                     32'd1);
            if (bus.cmd_valid) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_errors++;
                  $display("FAIL unexpected_cmd: got type %0d bank %0d, expected none (cyc %0d)",
                           bus.cmd_type, bus.cmd_ba, cyc);
               end else begin
                  e = sb.pop_front();
                  check_eq("cmd_cycle", 32'(cyc), 32'(e.vcyc));
                  check_eq("cmd_type", 32'(bus.cmd_type), 32'(e.typ));
                  check_eq("cmd_ba", 32'(bus.cmd_ba), 32'(e.ba));
                  check_eq("cmd_ra", 32'(bus.cmd_ra), 32'(e.ra));
                  check_eq("cmd_ca", 32'(bus.cmd_ca), 32'(e.ca));
                  check_eq("cmd_id", 32'(bus.cmd_id), 32'(e.id));
                  check_eq("cmd_len", 32'(bus.cmd_len), 32'(e.len));
               end
            end
         end
      end
   endtask

   initial begin
      fork
         monitor();
      join_none

      // Reset with every request high: nothing granted, nothing issued.
      clear_inputs();
      set_fields(1);
      bus.act_req = 4'hF;
      bus.rd_req  = 4'hF;
      bus.wr_req  = 4'hF;
      bus.pre_req = 4'hF;
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_act_gnt", 32'(bus.act_gnt), 32'd0);
      check_eq("rst_rd_gnt", 32'(bus.rd_gnt), 32'd0);
      check_eq("rst_wr_gnt", 32'(bus.wr_gnt), 32'd0);
      check_eq("rst_pre_gnt", 32'(bus.pre_gnt), 32'd0);
      check_eq("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
      bus.rd_req  = '0;
      bus.wr_req  = '0;
      bus.pre_req = '0;
      rst_n = 1'b1;
      #1;
      check_eq("first_act_gnt", 32'(bus.act_gnt), 32'h1);
      expect_cmd(T_ACT, 0, 1);
      expect_cmd(T_ACT, 1, 2);
      expect_cmd(T_ACT, 2, 3);
      expect_cmd(T_ACT, 3, 4);
      run(6);

      // tRRD spacing of 4 and a four-activate window of 21 cycles.
      do_reset(2);
      t_rrd_m1 = 4'd3;
      t_faw_m1 = 6'd20;
      bus.act_req = 4'hF;
      expect_cmd(T_ACT, 0, 1);
      expect_cmd(T_ACT, 1, 5);
      expect_cmd(T_ACT, 2, 9);
      expect_cmd(T_ACT, 3, 13);
      expect_cmd(T_ACT, 0, 22);
      run(13);
      bus.act_req[0] = 1'b1;
      run(7);
      #1;
      check_eq("faw_block_c20", 32'(bus.act_gnt), 32'd0);
      run(3);

      // RD beats a simultaneous ACT.
      do_reset(3);
      bus.rd_req  = 4'b0010;
      bus.act_req = 4'b0100;
      #1;
      check_eq("rd_over_act_rd", 32'(bus.rd_gnt), 32'b0010);
      check_eq("rd_over_act_act", 32'(bus.act_gnt), 32'd0);
      expect_cmd(T_RD, 1, 1);
      expect_cmd(T_ACT, 2, 2);
      run(4);

      // WR then RD held off by tWTR.
      do_reset(4);
      t_wtr_m1 = 4'd5;
      t_ccd_m1 = 4'd1;
      bus.wr_req = 4'b0001;
      bus.rd_req = 4'b0010;
      expect_cmd(T_WR, 0, 1);
      expect_cmd(T_RD, 1, 7);
      run(5);
      #1;
      check_eq("wtr_block_c5", 32'(bus.rd_gnt), 32'd0);
      run(4);

      // Same, with a WR on bank2 slipping past the blocked RD.
      do_reset(5);
      t_wtr_m1 = 4'd5;
      t_ccd_m1 = 4'd1;
      bus.wr_req = 4'b0101;
      bus.rd_req = 4'b0010;
      expect_cmd(T_WR, 0, 1);
      expect_cmd(T_WR, 2, 3);
      expect_cmd(T_RD, 1, 9);
      run(2);
      #1;
      check_eq("wr_skip_c2", 32'(bus.wr_gnt), 32'b0100);
      run(8);

      // Continuous reads, tCCD of 2, pointer wraps back to bank0.
      do_reset(6);
      t_ccd_m1 = 4'd1;
      expect_cmd(T_RD, 0, 1);
      expect_cmd(T_RD, 1, 3);
      expect_cmd(T_RD, 2, 5);
      expect_cmd(T_RD, 3, 7);
      expect_cmd(T_RD, 0, 9);
      for (int i = 0; i < 9; i++) begin
         bus.rd_req = 4'hF;
         tick();
      end
      bus.rd_req = '0;
      run(2);

      // PRE slips in while ACT waits on tRRD.
      do_reset(7);
      t_rrd_m1 = 4'd3;
      bus.act_req = 4'b0011;
      bus.pre_req = 4'b1000;
      expect_cmd(T_ACT, 0, 1);
      expect_cmd(T_PRE, 3, 2);
      expect_cmd(T_ACT, 1, 5);
      run(1);
      #1;
      check_eq("pre_while_rrd_pre", 32'(bus.pre_gnt), 32'b1000);
      check_eq("pre_while_rrd_act", 32'(bus.act_gnt), 32'd0);
      run(5);

      // Same bank RD and WR: RD first, WR after tRTW.
      do_reset(8);
      t_rtw_m1 = 4'd2;
      bus.rd_req = 4'b0001;
      bus.wr_req = 4'b0001;
      #1;
      check_eq("rd_wins_rd", 32'(bus.rd_gnt), 32'b0001);
      check_eq("rd_wins_wr", 32'(bus.wr_gnt), 32'd0);
      expect_cmd(T_RD, 0, 1);
      expect_cmd(T_WR, 0, 4);
      run(6);

      // Reset right after a grant drops the in-flight command.
      do_reset(9);
      bus.act_req = 4'b0100;
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
      check_eq("midrst_cmd_ba", 32'(bus.cmd_ba), 32'd0);
      check_eq("midrst_act_gnt", 32'(bus.act_gnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      expect_cmd(T_ACT, 2, 1);
      run(3);

      run(2);
      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
